// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared widths, lock FSM encodings and pixel type for the HDMI-in framer
package hdmi_pkg;
  localparam int XBITS_DEF       = 13;
  localparam int YBITS_DEF       = 11;
  localparam int LOCK_FRAMES_DEF = 2;

  localparam logic [1:0] ST_UNLOCK = 2'b00;
  localparam logic [1:0] ST_CHECK  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/hdmi_sync_edge.sv
// rtl/hdmi_sync_edge.sv - learns one sync line's polarity from DE and flags its active edge
module hdmi_sync_edge (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic sync_i,
  input  logic de_i,
  output logic active_o,
  output logic rise_o
);
  logic pol_q;
  logic pol_d;
  logic active_prev_q;

  // Sync is never asserted during active video, so its level under DE is the inactive one.
  assign pol_d    = de_i ? ~sync_i : pol_q;
  assign active_o = (sync_i == pol_q);
  assign rise_o   = active_o & ~active_prev_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pol_q         <= 1'b1;
      active_prev_q <= 1'b0;
    end else begin
      pol_q         <= pol_d;
      active_prev_q <= active_o;
    end
  end
endmodule

// File: rtl/hdmi_pix_framer.sv
// rtl/hdmi_pix_framer.sv - HDMI-in pixel framer: sync/DE to framing strobes, size measurement, lock
module hdmi_pix_framer
  import hdmi_pkg::*;
#(
  parameter int XBITS       = XBITS_DEF,
  parameter int YBITS       = YBITS_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             i_pix_clk,
  input  logic             i_reset_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic             i_de,
  input  logic [7:0]       i_r,
  input  logic [7:0]       i_g,
  input  logic [7:0]       i_b,
  output logic             o_pix_eof,
  output logic             o_pix_eol,
  output logic             o_pix_newline,
  output logic             o_pix_valid,
  output logic [7:0]       o_pix_r,
  output logic [7:0]       o_pix_g,
  output logic [7:0]       o_pix_b,
  output logic [XBITS-1:0] o_pix_npix,
  output logic [YBITS-1:0] o_pix_nlines,
  output logic             o_locked
);
  localparam logic [XBITS-1:0] XMAX = '1;
  localparam logic [YBITS-1:0] YMAX = '1;

  logic hs_q, vs_q, de_q, de_prev_q;
  rgb_t pix_q;

  always_ff @(posedge i_pix_clk) begin
    if (!i_reset_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      hs_q      <= i_hsync;
      vs_q      <= i_vsync;
      de_q      <= i_de;
      de_prev_q <= de_q;
      pix_q     <= '{r: i_r, g: i_g, b: i_b};
    end
  end

  logic de_rise, de_fall, eof_evt;
  logic hs_active_unused, hs_rise_unused, vs_active_unused;

  assign de_rise = de_q & ~de_prev_q;
  assign de_fall = ~de_q & de_prev_q;

  hdmi_sync_edge u_hsync (
    .clk_i     (i_pix_clk),
    .reset_n_i (i_reset_n),
    .sync_i    (hs_q),
    .de_i      (de_q),
    .active_o  (hs_active_unused),
    .rise_o    (hs_rise_unused)
  );

  hdmi_sync_edge u_vsync (
    .clk_i     (i_pix_clk),
    .reset_n_i (i_reset_n),
    .sync_i    (vs_q),
    .de_i      (de_q),
    .active_o  (vs_active_unused),
    .rise_o    (eof_evt)
  );

  logic [XBITS-1:0] xcnt_q, xcnt_d, npix_q, npix_d;
  logic [YBITS-1:0] ycnt_q, ycnt_d, nlines_q, nlines_d, ycnt_close;

  always_comb begin
    xcnt_d = xcnt_q;
    if (de_rise) begin
      xcnt_d = XBITS'(1);
    end else if (de_q && (xcnt_q != XMAX)) begin
      xcnt_d = xcnt_q + XBITS'(1);
    end
    npix_d = de_fall ? xcnt_q : npix_q;
  end

  // A line ending in the eof cycle still belongs to the frame being closed.
  always_comb begin
    ycnt_close = (de_fall && (ycnt_q != YMAX)) ? ycnt_q + YBITS'(1) : ycnt_q;
    ycnt_d     = eof_evt ? '0 : ycnt_close;
    nlines_d   = eof_evt ? ycnt_close : nlines_q;
  end

  logic [1:0]       state_q, state_d;
  logic [3:0]       fc_q, fc_d;
  logic [XBITS-1:0] prev_npix_q, prev_npix_d;
  logic [YBITS-1:0] prev_nlines_q, prev_nlines_d;
  logic             frame_ok;

  assign frame_ok = (npix_d == prev_npix_q) && (nlines_d == prev_nlines_q) &&
                    (npix_d != '0) && (nlines_d != '0);

  always_comb begin
    state_d       = state_q;
    fc_d          = fc_q;
    prev_npix_d   = prev_npix_q;
    prev_nlines_d = prev_nlines_q;
    if (eof_evt) begin
      prev_npix_d   = npix_d;
      prev_nlines_d = nlines_d;
      case (state_q)
        ST_UNLOCK: begin
          if (frame_ok) begin
            fc_d    = 4'd1;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            fc_d = fc_q + 4'd1;
            if ((fc_q + 4'd1) == 4'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end else begin
            fc_d    = 4'd0;
            state_d = ST_UNLOCK;
          end
        end
        ST_LOCKED: begin
          if (!frame_ok) begin
            fc_d    = 4'd0;
            state_d = ST_UNLOCK;
          end
        end
        default: begin
          fc_d    = 4'd0;
          state_d = ST_UNLOCK;
        end
      endcase
    end
  end

  logic eof_q, eol_q, newline_q, valid_q;
  rgb_t pix_out_q;

  always_ff @(posedge i_pix_clk) begin
    if (!i_reset_n) begin
      xcnt_q        <= '0;
      npix_q        <= '0;
      ycnt_q        <= '0;
      nlines_q      <= '0;
      state_q       <= ST_UNLOCK;
      fc_q          <= 4'd0;
      prev_npix_q   <= '0;
      prev_nlines_q <= '0;
      eof_q         <= 1'b0;
      eol_q         <= 1'b0;
      newline_q     <= 1'b0;
      valid_q       <= 1'b0;
      pix_out_q     <= '0;
    end else begin
      xcnt_q        <= xcnt_d;
      npix_q        <= npix_d;
      ycnt_q        <= ycnt_d;
      nlines_q      <= nlines_d;
      state_q       <= state_d;
      fc_q          <= fc_d;
      prev_npix_q   <= prev_npix_d;
      prev_nlines_q <= prev_nlines_d;
      eof_q         <= eof_evt;
      eol_q         <= de_fall;
      newline_q     <= de_rise;
      valid_q       <= de_q;
      pix_out_q     <= pix_q;
    end
  end

  assign o_pix_eof     = eof_q;
  assign o_pix_eol     = eol_q;
  assign o_pix_newline = newline_q;
  assign o_pix_valid   = valid_q;
  assign o_pix_r       = pix_out_q.r;
  assign o_pix_g       = pix_out_q.g;
  assign o_pix_b       = pix_out_q.b;
  assign o_pix_npix    = npix_q;
  assign o_pix_nlines  = nlines_q;
  assign o_locked      = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_hdmi_pix_framer.sv
// tb/tb_hdmi_pix_framer.sv - self-checking bench for hdmi_pix_framer
module tb_hdmi_pix_framer;
  localparam int XB   = 13;
  localparam int YB   = 11;
  localparam int LF   = 2;
  localparam int XMAX = (1 << XB) - 1;
  localparam int YMAX = (1 << YB) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;
  logic eof, eol, nl, valid, locked;
  logic [7:0] o_r, o_g, o_b;
  logic [XB-1:0] npix;
  logic [YB-1:0] nlines;

  always #5 clk = ~clk;

  hdmi_pix_framer #(.XBITS(XB), .YBITS(YB), .LOCK_FRAMES(LF)) dut (
    .i_pix_clk     (clk),
    .i_reset_n     (rst_n),
    .i_hsync       (hs),
    .i_vsync       (vs),
    .i_de          (de),
    .i_r           (r),
    .i_g           (g),
    .i_b           (b),
    .o_pix_eof     (eof),
    .o_pix_eol     (eol),
    .o_pix_newline (nl),
    .o_pix_valid   (valid),
    .o_pix_r       (o_r),
    .o_pix_g       (o_g),
    .o_pix_b       (o_b),
    .o_pix_npix    (npix),
    .o_pix_nlines  (nlines),
    .o_locked      (locked)
  );

  int n_assert = 0;
  int n_fail = 0;
  bit chk_on = 0;
  bit eof_chk = 0;
  bit hpos = 1, vpos = 1;
  // Input history, index k = input driven k cycles before the current one.
  logic h_de[1:3];
  logic h_va[1:3];
  logic [23:0] h_px[1:3];
  int fr_eol = 0, fr_eof = 0;
  bit both_seen = 0;
  int m_lines = 0, m_npix = 0, p_lines = 0, p_npix = 0, run = 0;
  bit exp_lock = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit hact, input bit vact, input bit d);
    logic [23:0] px;
    @(posedge clk);
    #1;
    if (chk_on) begin
      chk("valid", 32'(valid), 32'(h_de[2]));
      chk("newline", 32'(nl), 32'(h_de[2] & ~h_de[3]));
      chk("eol", 32'(eol), 32'(~h_de[2] & h_de[3]));
      chk("pixel", {8'h0, o_r, o_g, o_b}, {8'h0, h_px[2]});
      if (eof_chk) chk("eof", 32'(eof), 32'(h_va[2] & ~h_va[3]));
    end
    if (eol === 1'b1) fr_eol++;
    if (eof === 1'b1) fr_eof++;
    if (eol === 1'b1 && eof === 1'b1) both_seen = 1;
    px = d ? 24'($urandom) : 24'h0;
    hs = hact ? hpos : ~hpos;
    vs = vact ? vpos : ~vpos;
    de = d;
    {r, g, b} = px;
    h_de[3] = h_de[2]; h_de[2] = h_de[1]; h_de[1] = d & rst_n;
    h_va[3] = h_va[2]; h_va[2] = h_va[1]; h_va[1] = vact & rst_n;
    h_px[3] = h_px[2]; h_px[2] = h_px[1]; h_px[1] = rst_n ? px : 24'h0;
  endtask

  task automatic do_reset(input bit hp, input bit vp);
    chk_on = 0;
    rst_n = 1'b0;
    hpos = hp;
    vpos = vp;
    repeat (3) tick(0, 0, 0);
    rst_n = 1'b1;
    m_lines = 0; m_npix = 0; p_lines = 0; p_npix = 0; run = 0; exp_lock = 0;
    fr_eol = 0; fr_eof = 0; both_seen = 0;
    eof_chk = vp;
    chk_on = 1;
    tick(0, 0, 0);
    chk("rst_eof", 32'(eof), 0);
    chk("rst_eol", 32'(eol), 0);
    chk("rst_newline", 32'(nl), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_npix", 32'(npix), 0);
    chk("rst_nlines", 32'(nlines), 0);
    chk("rst_locked", 32'(locked), 0);
  endtask

  task automatic line(input int w, input int hb);
    for (int i = 0; i < w; i++) tick(0, 0, 1);
    for (int i = 0; i < hb; i++) tick(i < 2, 0, 0);
    m_lines = (m_lines < YMAX) ? m_lines + 1 : YMAX;
    m_npix = (w < XMAX) ? w : XMAX;
    if (!eof_chk) begin
      eof_chk = 1;
      fr_eof = 0;
    end
  endtask

  task automatic vsync_pulse();
    bit match;
    match = (m_npix == p_npix) && (m_lines == p_lines) && (m_npix != 0) && (m_lines != 0);
    run = match ? run + 1 : 0;
    exp_lock = (run >= LF);
    p_npix = m_npix;
    p_lines = m_lines;
    m_lines = 0;
    repeat (3) tick(0, 1, 0);
    repeat (5) tick(0, 0, 0);
  endtask

  task automatic frame_chk(input int eols);
    chk("npix", 32'(npix), p_npix);
    chk("nlines", 32'(nlines), p_lines);
    chk("locked", 32'(locked), 32'(exp_lock));
    chk("eof_count", fr_eof, 1);
    chk("eol_count", fr_eol, eols);
    fr_eol = 0;
    fr_eof = 0;
  endtask

  task automatic frame(input int w, input int n);
    for (int i = 0; i < n; i++) line(w, $urandom_range(4, 8));
    vsync_pulse();
    frame_chk(n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1, 1);
    repeat (3) tick(0, 0, 0);
    frame(8, 4);
    frame(8, 4);
    frame(8, 4);
    chk("locked_8x4", 32'(locked), 1);

    frame(8, 5);
    chk("unlock_8x5", 32'(locked), 0);
    frame(8, 5);
    frame(8, 5);
    chk("relock_8x5", 32'(locked), 1);

    for (int k = 0; k < 3; k++) frame($urandom_range(2, 16), $urandom_range(1, 5));
    begin
      int n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) line($urandom_range(1, 30), $urandom_range(4, 8));
      vsync_pulse();
      frame_chk(n);
    end

    do_reset(0, 0);
    repeat (3) tick(0, 0, 0);
    frame(8, 4);
    frame(8, 4);
    frame(8, 4);
    chk("locked_inverted", 32'(locked), 1);

    both_seen = 0;
    line(8, 5);
    line(8, 5);
    line(8, 0);
    vsync_pulse();
    frame_chk(3);
    chk("eof_eol_same_cycle", 32'(both_seen), 1);

    vsync_pulse();
    frame_chk(0);

    do_reset(1, 1);
    frame(9000, 1);
    chk("npix_saturated", 32'(npix), XMAX);
    frame(1, 3);
    chk("npix_single", 32'(npix), 1);

    for (int i = 0; i < 5; i++) tick(0, 0, 1);
    do_reset(1, 1);
    repeat (10) tick(0, 0, 0);
    chk("no_eol_after_reset", fr_eol, 0);
    chk("npix_after_reset", 32'(npix), 0);
    chk("nlines_after_reset", 32'(nlines), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
